// File: rtl/ip_ycbcr2rgb_if.sv
// Pixel stream bundle for the YCbCr-to-RGB converter: chroma/luma in with line
// strobes, clipped RGB out with delay-matched strobes.
interface ip_ycbcr2rgb_if #(
    parameter int CIW = 12,
    parameter int COW = 8
);
    logic [CIW-1:0] i_data_y;
    logic [CIW:0]   i_data_cb;
    logic [CIW:0]   i_data_cr;
    logic           i_hstr;
    logic           i_href;
    logic           i_hend;
    logic [COW-1:0] o_data_r;
    logic [COW-1:0] o_data_g;
    logic [COW-1:0] o_data_b;
    logic           o_hstr;
    logic           o_href;
    logic           o_hend;

    modport master (
        output i_data_y, i_data_cb, i_data_cr, i_hstr, i_href, i_hend,
        input  o_data_r, o_data_g, o_data_b, o_hstr, o_href, o_hend
    );

    modport slave (
        input  i_data_y, i_data_cb, i_data_cr, i_hstr, i_href, i_hend,
        output o_data_r, o_data_g, o_data_b, o_hstr, o_href, o_hend
    );
endinterface

// File: rtl/ip_ycbcr2rgb.sv
// Four-stage BT.601 YCbCr-to-RGB converter with S1.12 shift-add coefficients,
// round-half-up, output clipping and delay-matched line strobes.
module ip_ycbcr2rgb #(
    parameter int CIIW      = 8,
    parameter int CIPW      = 4,
    parameter int COIW      = 8,
    parameter int COPW      = 0,
    parameter int CIW       = CIIW + CIPW,
    parameter int COW       = COIW + COPW,
    parameter bit YCBCR_POS = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    ip_ycbcr2rgb_if.slave     bus
);
    localparam int ACW   = CIW + 16;
    localparam int SHIFT = 12 + CIPW - COPW;
    localparam logic [CIW:0]            CHROMA_OFS = (CIW + 1)'(128 << CIPW);
    localparam logic signed [ACW-1:0]   RND        = ACW'(64'd1 << (SHIFT - 1));
    localparam logic signed [ACW-1:0]   OMAX       = ACW'((64'd1 << COW) - 64'd1);

    // Offset removal happens ahead of stage 1 so a reset (zero) stage 1 is neutral chroma.
    logic [CIW:0] cb_in, cr_in;
    always_comb begin
        cb_in = bus.i_data_cb;
        cr_in = bus.i_data_cr;
        if (YCBCR_POS) begin
            cb_in = bus.i_data_cb - CHROMA_OFS;
            cr_in = bus.i_data_cr - CHROMA_OFS;
        end
    end

    logic [CIW-1:0]        y1;
    logic signed [CIW:0]   cb1, cr1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1  <= '0;
            cb1 <= '0;
            cr1 <= '0;
        end else begin
            y1  <= bus.i_data_y;
            cb1 <= cb_in;
            cr1 <= cr_in;
        end
    end

    logic signed [ACW-1:0] y_x, cb_x, cr_x;
    assign y_x  = {{(ACW - CIW){1'b0}}, y1};
    assign cb_x = {{(ACW - CIW - 1){cb1[CIW]}}, cb1};
    assign cr_x = {{(ACW - CIW - 1){cr1[CIW]}}, cr1};

    // 5743 = 5696 + 47, 2925 = 2880 + 45, 7258 = 7232 + 26, 1410 kept whole.
    logic signed [ACW-1:0] y2, r_a2, r_b2, g_cb2, g_cr_a2, g_cr_b2, b_a2, b_b2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y2      <= '0;
            r_a2    <= '0;
            r_b2    <= '0;
            g_cb2   <= '0;
            g_cr_a2 <= '0;
            g_cr_b2 <= '0;
            b_a2    <= '0;
            b_b2    <= '0;
        end else begin
            y2      <= y_x <<< 12;
            r_a2    <= (cr_x <<< 12) + (cr_x <<< 10) + (cr_x <<< 9) + (cr_x <<< 6);
            r_b2    <= (cr_x <<< 5) + (cr_x <<< 3) + (cr_x <<< 2) + (cr_x <<< 1) + cr_x;
            g_cb2   <= (cb_x <<< 10) + (cb_x <<< 8) + (cb_x <<< 7) + (cb_x <<< 1);
            g_cr_a2 <= (cr_x <<< 11) + (cr_x <<< 9) + (cr_x <<< 8) + (cr_x <<< 6);
            g_cr_b2 <= (cr_x <<< 5) + (cr_x <<< 3) + (cr_x <<< 2) + cr_x;
            b_a2    <= (cb_x <<< 12) + (cb_x <<< 11) + (cb_x <<< 10) + (cb_x <<< 6);
            b_b2    <= (cb_x <<< 4) + (cb_x <<< 3) + (cb_x <<< 1);
        end
    end

    logic signed [ACW-1:0] r_sum, g_sum, b_sum;
    assign r_sum = y2 + r_a2 + r_b2 + RND;
    assign g_sum = y2 - g_cb2 - g_cr_a2 - g_cr_b2 + RND;
    assign b_sum = y2 + b_a2 + b_b2 + RND;

    logic signed [ACW-1:0] r3, g3, b3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3 <= '0;
            g3 <= '0;
            b3 <= '0;
        end else begin
            r3 <= r_sum >>> SHIFT;
            g3 <= g_sum >>> SHIFT;
            b3 <= b_sum >>> SHIFT;
        end
    end

    function automatic logic [COW-1:0] clip(input logic signed [ACW-1:0] v);
        if (v[ACW-1])
            return '0;
        else if (v > OMAX)
            return '1;
        else
            return v[COW-1:0];
    endfunction

    logic [COW-1:0] r4, g4, b4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r4 <= '0;
            g4 <= '0;
            b4 <= '0;
        end else begin
            r4 <= clip(r3);
            g4 <= clip(g3);
            b4 <= clip(b3);
        end
    end

    logic [11:0] sync_sr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_sr <= '0;
        else
            sync_sr <= {sync_sr[8:0], bus.i_hstr, bus.i_href, bus.i_hend};
    end

    assign bus.o_data_r = r4;
    assign bus.o_data_g = g4;
    assign bus.o_data_b = b4;
    assign bus.o_hstr   = sync_sr[11];
    assign bus.o_href   = sync_sr[10];
    assign bus.o_hend   = sync_sr[9];
endmodule

// File: tb/tb_ip_ycbcr2rgb.sv
// Bench for ip_ycbcr2rgb: offset-binary and two's-complement instances driven
// side by side and compared against a real-arithmetic reference delayed 4 cycles.
module tb_ip_ycbcr2rgb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ip_ycbcr2rgb_if #(.CIW(12), .COW(8)) bus_p ();
    ip_ycbcr2rgb_if #(.CIW(12), .COW(8)) bus_s ();

    ip_ycbcr2rgb #(
        .CIIW(8), .CIPW(4), .COIW(8), .COPW(0), .YCBCR_POS(1'b1)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p)
    );

    ip_ycbcr2rgb #(
        .CIIW(8), .CIPW(4), .COIW(8), .COPW(0), .YCBCR_POS(1'b0)
    ) u_sgn (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    // {r, g, b, hstr, href, hend} expected per output cycle
    logic [26:0] q_p[$];
    logic [26:0] q_s[$];

    function automatic int rnd_half_up(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic logic [7:0] clip8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // y in 1/16 units, cb/cr already signed (offset removed), 1/16 units
    function automatic logic [23:0] model(input int y, input int cb, input int cr);
        real rr, gg, bb;
        rr = (4096.0 * y + 5743.0 * cr) / 65536.0;
        gg = (4096.0 * y - 1410.0 * cb - 2925.0 * cr) / 65536.0;
        bb = (4096.0 * y + 7258.0 * cb) / 65536.0;
        return {clip8(rnd_half_up(rr)), clip8(rnd_half_up(gg)), clip8(rnd_half_up(bb))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pos_rgb"}, {8'h0, bus_p.o_data_r, bus_p.o_data_g, bus_p.o_data_b}, 32'h0);
        check({tag, "_pos_sync"}, {29'h0, bus_p.o_hstr, bus_p.o_href, bus_p.o_hend}, 32'h0);
        check({tag, "_sgn_rgb"}, {8'h0, bus_s.o_data_r, bus_s.o_data_g, bus_s.o_data_b}, 32'h0);
        check({tag, "_sgn_sync"}, {29'h0, bus_s.o_hstr, bus_s.o_href, bus_s.o_hend}, 32'h0);
    endtask

    task automatic prefill();
        q_p.delete();
        q_s.delete();
        repeat (3) begin
            q_p.push_back(27'h0);
            q_s.push_back(27'h0);
        end
    endtask

    // ycp/cbp/crp: offset-binary raw codes; cbs/crs: signed values for the signed instance
    task automatic step(input string tag, input int y, input int cbp, input int crp,
                        input int cbs, input int crs, input bit hs, input bit hr, input bit he);
        logic [26:0] ep, es;
        bus_p.i_data_y  = 12'(y);
        bus_p.i_data_cb = 13'(cbp);
        bus_p.i_data_cr = 13'(crp);
        bus_s.i_data_y  = 12'(y);
        bus_s.i_data_cb = 13'(cbs);
        bus_s.i_data_cr = 13'(crs);
        {bus_p.i_hstr, bus_p.i_href, bus_p.i_hend} = {hs, hr, he};
        {bus_s.i_hstr, bus_s.i_href, bus_s.i_hend} = {hs, hr, he};
        q_p.push_back({model(y, cbp - 2048, crp - 2048), hs, hr, he});
        q_s.push_back({model(y, cbs, crs), hs, hr, he});
        @(posedge clk);
        #1;
        ep = q_p.pop_front();
        es = q_s.pop_front();
        check({tag, "_pos_rgb"}, {8'h0, bus_p.o_data_r, bus_p.o_data_g, bus_p.o_data_b}, {8'h0, ep[26:3]});
        check({tag, "_pos_sync"}, {29'h0, bus_p.o_hstr, bus_p.o_href, bus_p.o_hend}, {29'h0, ep[2:0]});
        check({tag, "_sgn_rgb"}, {8'h0, bus_s.o_data_r, bus_s.o_data_g, bus_s.o_data_b}, {8'h0, es[26:3]});
        check({tag, "_sgn_sync"}, {29'h0, bus_s.o_hstr, bus_s.o_href, bus_s.o_hend}, {29'h0, es[2:0]});
    endtask

    task automatic rand_step(input string tag, input bit hs, input bit hr, input bit he);
        step(tag, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 4095)) - 2048, hs, hr, he);
    endtask

    initial begin
        bus_p.i_data_y = '0; bus_p.i_data_cb = '0; bus_p.i_data_cr = '0;
        bus_s.i_data_y = '0; bus_s.i_data_cb = '0; bus_s.i_data_cr = '0;
        {bus_p.i_hstr, bus_p.i_href, bus_p.i_hend} = 3'b000;
        {bus_s.i_hstr, bus_s.i_href, bus_s.i_hend} = 3'b000;

        #3;
        check_zero("reset_now");
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset_held");

        rst_n = 1'b1;
        prefill();
        // directed corner pixels: gray, over-range, under-range, signed-mode sample
        step("gray",  2048, 2048, 2048,     0, -1024, 1'b0, 1'b0, 1'b0);
        step("over",  4080, 2048, 4080,  2047,  2047, 1'b0, 1'b0, 1'b0);
        step("under",    0,    0,    0, -2048, -2048, 1'b0, 1'b0, 1'b0);
        step("mixed", 2048, 4095,    0, -1024,  1024, 1'b1, 1'b1, 1'b1);
        repeat (4) step("flush", 2048, 2048, 2048, 0, 0, 1'b0, 1'b0, 1'b0);

        // line with hstr at 10, href 10..19 with a gap at 15, hend at 19
        for (int i = 0; i < 30; i++)
            rand_step("line", i == 10, (i >= 10 && i <= 19 && i != 15), i == 19);

        // line interrupted by reset at cycle 12
        for (int i = 0; i < 12; i++)
            rand_step("pre_rst", i == 10, i >= 10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midline_rst");
        @(posedge clk); @(posedge clk); #1;
        check_zero("midline_held");
        rst_n = 1'b1;
        prefill();
        for (int i = 0; i < 20; i++)
            rand_step("post_rst", i == 2, (i >= 2 && i <= 9), i == 9);
        for (int i = 0; i < 6; i++)
            rand_step("one_px", i == 1, i == 1, i == 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
